// File: rtl/rr_arb8_dec_pkg.sv
// Shared definitions for the 8-way round-robin arbiter slice.
//   NUM_REQ          number of requesters
//   IDX_W            width of a requester index
//   arb_state_e      arbiter FSM states (IDLE, OWN)
//   DEFAULT_TIMEOUT  default watchdog hold limit in cycles
//   DEFAULT_CNT_W    default hold-counter width (2**CNT_W > TIMEOUT)
package rr_arb8_dec_pkg;

    localparam int NUM_REQ         = 8;
    localparam int IDX_W           = 3;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb8_dec_if.sv
// Requester/arbiter bundle for rr_arb8_dec.
//   req        requester -> arbiter, request vector
//   gnt        arbiter -> requester, one-hot grant (zero when no owner)
//   gnt_idx    arbiter -> datapath, owner index (valid with gnt_valid)
//   gnt_valid  arbiter -> requester, an owner currently holds the grant
//   timeout    arbiter -> requester, 1-cycle pulse on watchdog revocation
// Modports: master = requester side, slave = arbiter side.
interface rr_arb8_dec_if;
    import rr_arb8_dec_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid, input timeout);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output timeout);

endinterface

// File: rtl/rr_arb8_dec_onehot.sv
// onehot_dec3: combinational 3-to-8 one-hot decoder (onehot = 1 << idx).
//   idx     in   3  index to decode
//   onehot  out  8  decoded one-hot vector
module onehot_dec3
    import rr_arb8_dec_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    assign onehot = NUM_REQ'(1) << idx;

endmodule

// File: rtl/rr_arb8_dec.sv
// rr_arb8_dec: 8-way round-robin arbiter with registered one-hot grant.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of rr_arb8_dec_if (req in; gnt, gnt_idx, gnt_valid, timeout out)
// An owner keeps the grant until it drops its request; every handover passes
// through one IDLE cycle with gnt=0. After owner k releases, the search starts
// at k+1 so k has lowest priority next time.
// Optional feature: define GRANT_TIMEOUT_EN to add a hold watchdog that revokes
// a grant after TIMEOUT cycles and pulses timeout. Without it timeout is tied 0.
module rr_arb8_dec
    import rr_arb8_dec_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
)(
    input  logic            clk,
    input  logic            rst,
    rr_arb8_dec_if.slave    bus
);

    // Reject configurations the hold counter cannot represent.
    if (TIMEOUT < 2 || TIMEOUT > 31 || (2 ** CNT_W) <= TIMEOUT) begin : g_cfg_check
        $error("rr_arb8_dec: illegal TIMEOUT/CNT_W combination");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_dec;

`ifdef GRANT_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W-1:0]     win_idx;

    // Rotate req so bit i is requester (ptr+i) mod 8, find the lowest set bit,
    // then map the offset back to an absolute index with 3-bit wraparound.
    always_comb begin
        req_dbl = {bus.req, bus.req};
        req_rot = req_dbl[ptr_q +: NUM_REQ];
        win_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = IDX_W'(i);
            end
        end
        win_idx = ptr_q + win_off;
    end

    // Next-state logic. A release is checked before the watchdog so a normal
    // drop on the limit cycle never produces a timeout pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    state_d = OWN;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
`ifdef GRANT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            OWN: begin
                if (!bus.req[idx_q]) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + IDX_W'(1);
                end
`ifdef GRANT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = idx_q + IDX_W'(1);
                end
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Decode the next owner index; gating with valid_d keeps gnt at zero in IDLE.
    onehot_dec3 u_dec (
        .idx    (idx_d),
        .onehot (gnt_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_dec & {NUM_REQ{valid_d}};
        end
    end

`ifdef GRANT_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule
